serial_paralelo: RTL and testbench



---
 rtl/serial_paralelo_pkg.sv | 22 ++
 rtl/serial_paralelo_if.sv | 39 +++
 rtl/serial_paralelo_shift_in.sv | 24 ++
 rtl/serial_paralelo.sv | 116 +++++++++++
 tb/tb_serial_paralelo.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/serial_paralelo_pkg.sv
// Shared serial-link definitions: comma symbol, byte width and the
// receiver alignment state encoding. The same constants are used by the
// paralelo_serial transmitter.
package serial_link_pkg;

    localparam int BYTE_W = 8;

    // Idle / alignment symbol, sent MSB first (1,0,1,1,1,1,0,0)
    localparam logic [BYTE_W-1:0] COMMA_BYTE = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } link_state_t;

    // Saturating 8-bit increment, used by the optional idle counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/serial_paralelo_if.sv
// Signal bundle between the serial source and the serial_paralelo receiver.
// Optional idle_cnt member present when SERIAL_PARALELO_IDLE_CNT_EN is defined.
interface serial_paralelo_if;
    import serial_link_pkg::*;

    logic              serial_in;
    logic [BYTE_W-1:0] data_out;
    logic              valid_out;
    logic              byte_stb;
    logic              active;
`ifdef SERIAL_PARALELO_IDLE_CNT_EN
    logic [7:0]        idle_cnt;
`endif

    // Source side: drives the serial stream, observes recovered bytes
    modport master (
        output serial_in,
        input  data_out,
        input  valid_out,
        input  byte_stb,
`ifdef SERIAL_PARALELO_IDLE_CNT_EN
        input  idle_cnt,
`endif
        input  active
    );

    // Receiver side
    modport slave (
        input  serial_in,
        output data_out,
        output valid_out,
        output byte_stb,
`ifdef SERIAL_PARALELO_IDLE_CNT_EN
        output idle_cnt,
`endif
        output active
    );

endinterface

// File: rtl/serial_paralelo_shift_in.sv
// serial_shift_in: 8-bit MSB-first input shift register. nxt is the byte
// completed by the bit currently on serial_in; is_comma flags it as idle.
module serial_shift_in
    import serial_link_pkg::*;
(
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              serial_in,
    output logic [BYTE_W-1:0] nxt,
    output logic              is_comma
);

    logic [BYTE_W-1:0] sh_reg;

    assign nxt      = {sh_reg[BYTE_W-2:0], serial_in};
    assign is_comma = (nxt == COMMA_BYTE);

    // Shift one bit per edge; cleared to zero so no comma matches early
    always_ff @(posedge clk_32f) begin
        if (reset) sh_reg <= '0;
        else       sh_reg <= nxt;
    end

endmodule

// File: rtl/serial_paralelo.sv
// serial_paralelo: serial-to-byte receiver with comma-based alignment.
// Searches for COMMA_BYTE, requires LOCK_COUNT consecutive aligned commas,
// then outputs each non-comma byte, held for a full byte period.
// Optional: define SERIAL_PARALELO_IDLE_CNT_EN to add the idle_cnt output.
module serial_paralelo
    import serial_link_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4   // legal range 1..15
) (
    input  logic         clk_32f,
    input  logic         reset,
    serial_paralelo_if.slave link
);

    localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

    logic [BYTE_W-1:0] nxt;
    logic              is_comma;

    link_state_t       state_reg;
    logic [2:0]        bit_cnt_reg;
    logic [3:0]        comma_cnt_reg;
    logic [BYTE_W-1:0] data_out_reg;
    logic              valid_reg;
    logic              stb_reg;
    logic              active_reg;
    logic              boundary;

    serial_shift_in u_shift (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .serial_in (link.serial_in),
        .nxt       (nxt),
        .is_comma  (is_comma)
    );

    // bit_cnt==7 means the current bit is the LSB of an aligned byte
    assign boundary = (bit_cnt_reg == 3'd7);

`ifdef SERIAL_PARALELO_IDLE_CNT_EN
    logic [7:0] idle_cnt_reg;
    assign link.idle_cnt = idle_cnt_reg;
`endif

    // Alignment FSM with registered byte outputs
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_reg     <= SEARCH;
            bit_cnt_reg   <= 3'd0;
            comma_cnt_reg <= 4'd0;
            data_out_reg  <= '0;
            valid_reg     <= 1'b0;
            stb_reg       <= 1'b0;
            active_reg    <= 1'b0;
`ifdef SERIAL_PARALELO_IDLE_CNT_EN
            idle_cnt_reg  <= 8'd0;
`endif
        end else begin
            stb_reg <= 1'b0;
            case (state_reg)
                SEARCH: begin
                    if (is_comma) begin
                        bit_cnt_reg   <= 3'd0;
                        comma_cnt_reg <= 4'd1;
                        if (LOCK_COUNT == 1) begin
                            state_reg  <= ACTIVE;
                            active_reg <= 1'b1;
                        end else begin
                            state_reg  <= LOCKING;
                        end
                    end
                end
                LOCKING: begin
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (boundary) begin
                        if (is_comma) begin
                            comma_cnt_reg <= comma_cnt_reg + 4'd1;
                            if (comma_cnt_reg + 4'd1 == LOCK_CNT4) begin
                                state_reg  <= ACTIVE;
                                active_reg <= 1'b1;
                            end
                        end else begin
                            state_reg     <= SEARCH;
                            comma_cnt_reg <= 4'd0;
                        end
                    end
                end
                ACTIVE: begin
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (boundary) begin
                        if (is_comma) begin
                            valid_reg    <= 1'b0;
`ifdef SERIAL_PARALELO_IDLE_CNT_EN
                            idle_cnt_reg <= sat_inc8(idle_cnt_reg);
`endif
                        end else begin
                            data_out_reg <= nxt;
                            valid_reg    <= 1'b1;
                            stb_reg      <= 1'b1;
`ifdef SERIAL_PARALELO_IDLE_CNT_EN
                            idle_cnt_reg <= 8'd0;
`endif
                        end
                    end
                end
                default: state_reg <= SEARCH;
            endcase
        end
    end

    assign link.data_out  = data_out_reg;
    assign link.valid_out = valid_reg;
    assign link.byte_stb  = stb_reg;
    assign link.active    = active_reg;

endmodule

// File: tb/tb_serial_paralelo.sv
// Testbench for serial_paralelo: stimulus pushes the expected per-cycle
// outputs from a stream-level reference model into a queue; an independent
// monitor pops and compares after every clock edge.
// idle_cnt is checked when SERIAL_PARALELO_IDLE_CNT_EN is defined.
module tb_serial_paralelo;

    localparam int          LC    = 4;
    localparam logic [7:0]  COMMA = 8'hBC;

    typedef struct packed {
        logic       active;
        logic       valid;
        logic       stb;
        logic [7:0] data;
        logic [7:0] idle;
    } exp_t;

    logic clk_32f;
    logic reset;

    serial_paralelo_if link_if ();

    serial_paralelo #(.LOCK_COUNT(LC)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .link    (link_if)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model: tracks the received bit stream since reset.
    // Alignment is an anchor position; boundaries are positions that are a
    // whole number of bytes after the anchor.
    logic [7:0] m_win;
    int         m_pos, m_anchor, m_run;
    logic       m_locked;
    exp_t       m_out;

    task automatic model_reset();
        m_win    = 8'h00;
        m_pos    = 0;
        m_anchor = -1;
        m_run    = 0;
        m_locked = 1'b0;
        m_out    = '0;
    endtask

    task automatic model_step(input logic b, input logic r);
        if (r) begin
            model_reset();
        end else begin
            m_out.stb = 1'b0;
            m_pos++;
            m_win = (8'((m_win * 2) % 256)) | {7'd0, b};
            if (!m_locked) begin
                if (m_anchor < 0) begin
                    if (m_win == COMMA) begin
                        m_anchor = m_pos;
                        m_run    = 1;
                    end
                end else if ((m_pos - m_anchor) % 8 == 0) begin
                    if (m_win == COMMA) m_run++;
                    else begin
                        m_anchor = -1;
                        m_run    = 0;
                    end
                end
                if (m_anchor >= 0 && m_run >= LC) begin
                    m_locked     = 1'b1;
                    m_out.active = 1'b1;
                end
            end else if ((m_pos - m_anchor) % 8 == 0) begin
                if (m_win == COMMA) begin
                    m_out.valid = 1'b0;
                    if (m_out.idle != 8'd255) m_out.idle = m_out.idle + 8'd1;
                end else begin
                    m_out.data  = m_win;
                    m_out.valid = 1'b1;
                    m_out.stb   = 1'b1;
                    m_out.idle  = 8'd0;
                end
            end
        end
    endtask

    task automatic drive_bit(input logic b, input logic r);
        @(negedge clk_32f);
        link_if.serial_in = b;
        reset             = r;
        model_step(b, r);
        exp_q.push_back(m_out);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) drive_bit(v[i], 1'b0);
    endtask

    task automatic send_rand_data(input int count);
        logic [7:0] v;
        for (int i = 0; i < count; i++) begin
            v = 8'($urandom_range(0, 255));
            if (v == COMMA) v = 8'h3C;
            if ($urandom_range(0, 3) == 0) send_byte(COMMA);
            send_byte(v);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, req, $time);
    endtask

    // Monitor: compare DUT outputs with the queued expectation after each edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_32f);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("active",    {7'd0, link_if.active},    {7'd0, e.active});
                chk("valid_out", {7'd0, link_if.valid_out}, {7'd0, e.valid});
                chk("byte_stb",  {7'd0, link_if.byte_stb},  {7'd0, e.stb});
                chk("data_out",  link_if.data_out,          e.data);
`ifdef SERIAL_PARALELO_IDLE_CNT_EN
                chk("idle_cnt",  link_if.idle_cnt,          e.idle);
`endif
            end
        end
    end

    initial begin : stimulus
        model_reset();
        reset             = 1'b1;
        link_if.serial_in = 1'b0;

        // Reset held while serial_in toggles
        for (int i = 0; i < 3; i++) drive_bit(i[0], 1'b1);

        // Lock after 3 random bits and 4 commas, then 5A, BC, C3
        for (int i = 0; i < 3; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        send_byte(8'h5A);
        send_byte(COMMA);
        send_byte(8'hC3);
        send_rand_data(20);

        // Abort during lock: BC BC 00 then 4 clean BCs
        drive_bit(1'b0, 1'b1);
        send_byte(COMMA);
        send_byte(COMMA);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        send_rand_data(6);

        // Reset pulse mid-byte while streaming 77, then relock
        send_byte(8'h77);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b1);
        send_byte(8'h77);
        for (int i = 0; i < 3; i++) send_byte(COMMA);
        send_byte(8'h77);
        for (int i = 0; i < 4; i++) send_byte(COMMA);
        send_rand_data(6);

        // Long idle run (idle counter saturation) then data 11
        for (int i = 0; i < 300; i++) send_byte(COMMA);
        send_byte(8'h11);
        send_byte(COMMA);

        // All-zero stream never locks
        drive_bit(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) drive_bit(1'b0, 1'b0);

        // Random bit stream from reset, then aligned traffic
        for (int i = 0; i < 400; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 5; i++) send_byte(COMMA);
        send_rand_data(10);

        // Drain the scoreboard within a bounded number of cycles
        repeat (4) @(posedge clk_32f);
        #2;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
